// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: pops one send-FIFO entry per frame and serialises it as
// start bit, LSB-first data bits, optional parity bit and one stop bit.
module uart_tx_sequencer #(
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_DATA_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] baud_rate_i,
   input  logic [3:0]            data_bits_i,
   input  logic                  parity_en_i,
   input  logic                  odd_parity_i,
   input  logic                  send_data_i,
   output logic                  send_data_clr_o,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   output logic                  fifo_pop_o,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  data_bits_error_o,
   output logic                  frame_done_o
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   state_e                   state_q;
   logic                     tx_q, busy_q, err_q, done_q;
   logic [DATA_WIDTH-1:0]    cnt_q, baud_m1_q, baud_m1_d;
   logic [MAX_DATA_BITS-1:0] shift_q;
   logic [3:0]               bits_q;
   logic                     par_en_q, par_q, par_d;
   logic                     bits_legal;

   assign bits_legal = (data_bits_i != 4'd0) && (data_bits_i <= 4'(MAX_DATA_BITS));

   // Pop and clear are handshakes with the FIFO/CSR that act on the edge closing this
   // cycle, so they are decoded combinationally; a registered version would repeat.
   assign fifo_pop_o      = (state_q == IDLE) && send_data_i && bits_legal && !fifo_empty_i;
   assign send_data_clr_o = (state_q == IDLE) && send_data_i && (!bits_legal || fifo_empty_i);

   always_comb begin
      // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
      par_d     = odd_parity_i;
      baud_m1_d = (baud_rate_i == '0) ? '0 : baud_rate_i - DATA_WIDTH'(1);
      for (int i = 0; i < MAX_DATA_BITS; i++) begin
         if (i < int'(data_bits_i)) par_d = par_d ^ fifo_data_i[i];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
         baud_m1_q <= '0;
         shift_q   <= '0;
         bits_q    <= '0;
         par_en_q  <= 1'b0;
         par_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (fifo_pop_o) begin
                  state_q   <= START;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  err_q     <= 1'b0;
                  cnt_q     <= baud_m1_d;
                  baud_m1_q <= baud_m1_d;
                  shift_q   <= fifo_data_i[MAX_DATA_BITS-1:0];
                  bits_q    <= data_bits_i;
                  par_en_q  <= parity_en_i;
                  par_q     <= par_d;
               end else if (send_data_i && !bits_legal) begin
                  err_q <= 1'b1;
               end
            end
            START: begin
               if (cnt_q == '0) begin
                  state_q <= DATA;
                  tx_q    <= shift_q[0];
                  cnt_q   <= baud_m1_q;
               end else begin
                  cnt_q <= cnt_q - DATA_WIDTH'(1);
               end
            end
            DATA: begin
               if (cnt_q == '0) begin
                  cnt_q <= baud_m1_q;
                  if (bits_q == 4'd1) begin
                     state_q <= par_en_q ? PARITY : STOP;
                     tx_q    <= par_en_q ? par_q : 1'b1;
                  end else begin
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                     bits_q  <= bits_q - 4'd1;
                  end
               end else begin
                  cnt_q <= cnt_q - DATA_WIDTH'(1);
               end
            end
            PARITY: begin
               if (cnt_q == '0) begin
                  state_q <= STOP;
                  tx_q    <= 1'b1;
                  cnt_q   <= baud_m1_q;
               end else begin
                  cnt_q <= cnt_q - DATA_WIDTH'(1);
               end
            end
            STOP: begin
               if (cnt_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - DATA_WIDTH'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_o              = tx_q;
   assign busy_o            = busy_q;
   assign data_bits_error_o = err_q;
   assign frame_done_o      = done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: small FIFO model, per-cycle line checks,
// pulse counters and hand-computed frame bit patterns.
module tb_uart_tx_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] baud_rate_i;
   logic [3:0]  data_bits_i;
   logic        parity_en_i, odd_parity_i, send_data_i;
   logic        send_data_clr_o, fifo_empty_i, fifo_pop_o;
   logic [31:0] fifo_data_i;
   logic        tx_o, busy_o, data_bits_error_o, frame_done_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] fifo_mem [16];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   int          pop_cnt = 0, busy_cnt = 0, done_cnt = 0;

   always #5 clk = ~clk;

   assign fifo_empty_i = (rd_ptr == wr_ptr);
   assign fifo_data_i  = fifo_mem[rd_ptr % 16];

   always @(posedge clk) begin
      if (fifo_pop_o) begin
         rd_ptr  <= rd_ptr + 1;
         pop_cnt <= pop_cnt + 1;
      end
      if (busy_o)       busy_cnt <= busy_cnt + 1;
      if (frame_done_o) done_cnt <= done_cnt + 1;
   end

   uart_tx_sequencer #(.DATA_WIDTH(32), .MAX_DATA_BITS(8)) dut (
      .clk               (clk),
      .rst               (rst),
      .baud_rate_i       (baud_rate_i),
      .data_bits_i       (data_bits_i),
      .parity_en_i       (parity_en_i),
      .odd_parity_i      (odd_parity_i),
      .send_data_i       (send_data_i),
      .send_data_clr_o   (send_data_clr_o),
      .fifo_empty_i      (fifo_empty_i),
      .fifo_data_i       (fifo_data_i),
      .fifo_pop_o        (fifo_pop_o),
      .tx_o              (tx_o),
      .busy_o            (busy_o),
      .data_bits_error_o (data_bits_error_o),
      .frame_done_o      (frame_done_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] d);
      fifo_mem[wr_ptr % 16] = d;
      wr_ptr++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for the pop, then checks every cycle of the frame and the done cycle.
   // b/n/pen/odd/data describe the frame as latched; chg_bits >= 0 rewrites CSRs mid-frame.
   task automatic send_frame(input string tag, input int b, input int n, input bit pen,
                             input bit odd, input logic [31:0] data, input int chg_bits,
                             output int waited);
      logic p, e;
      int   len;
      waited = 0;
      #1;
      while (fifo_pop_o !== 1'b1 && waited < 200) begin
         step();
         waited++;
      end
      check({tag, "_pop"}, fifo_pop_o, 1);
      p = odd;
      for (int i = 0; i < n; i++) p = p ^ data[i];
      len = 2 + n + (pen ? 1 : 0);
      for (int j = 0; j < len; j++) begin
         if (j == 0)                  e = 1'b0;
         else if (j <= n)             e = data[j-1];
         else if (pen && j == n + 1)  e = p;
         else                         e = 1'b1;
         for (int c = 0; c < b; c++) begin
            step();
            if (j == 0 && c == 0 && chg_bits >= 0) begin
               data_bits_i = 4'(chg_bits);
               baud_rate_i = 32'd7;
               parity_en_i = 1'b0;
            end
            check($sformatf("%s_bit%0d", tag, j), tx_o, e);
            check($sformatf("%s_busy%0d", tag, j), busy_o, 1);
         end
      end
      step();
      check({tag, "_done"}, frame_done_o, 1);
      check({tag, "_idle_busy"}, busy_o, 0);
      check({tag, "_idle_tx"}, tx_o, 1);
   endtask

   initial begin
      int w, p0, b0, d0;
      rst          = 1'b1;
      baud_rate_i  = 32'd4;
      data_bits_i  = 4'd8;
      parity_en_i  = 1'b1;
      odd_parity_i = 1'b1;
      send_data_i  = 1'b0;
      repeat (3) step();
      check("rst_tx", tx_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_err", data_bits_error_o, 0);
      check("rst_done", frame_done_o, 0);
      rst = 1'b0;
      step();
      check("idle_pop", fifo_pop_o, 0);
      check("idle_clr", send_data_clr_o, 0);

      // 1: B=4, N=8, odd parity, 0x55
      push(32'h55);
      p0 = pop_cnt; b0 = busy_cnt; d0 = done_cnt;
      send_data_i = 1'b1;
      send_frame("t1", 4, 8, 1, 1, 32'h55, -1, w);
      check("t1_latency", w, 0);
      check("t1_busy_cycles", busy_cnt - b0, 44);
      check("t1_pops", pop_cnt - p0, 1);
      check("t1_clr", send_data_clr_o, 1);
      send_data_i = 1'b0;
      step();
      check("t1_done_cnt", done_cnt - d0, 1);
      check("t1_clr_off", send_data_clr_o, 0);

      // 2: even parity 0x55; N=5 no parity 0x1F; N=3 even with ignored upper bits
      odd_parity_i = 1'b0;
      push(32'h55);
      send_data_i = 1'b1;
      send_frame("t2a", 4, 8, 1, 0, 32'h55, -1, w);
      send_data_i = 1'b0;
      step();
      baud_rate_i = 32'd3; data_bits_i = 4'd5; parity_en_i = 1'b0;
      push(32'h1F);
      b0 = busy_cnt;
      send_data_i = 1'b1;
      send_frame("t2b", 3, 5, 0, 0, 32'h1F, -1, w);
      check("t2b_busy_cycles", busy_cnt - b0, 21);
      send_data_i = 1'b0;
      step();
      data_bits_i = 4'd3; parity_en_i = 1'b1;
      push(32'h0D);
      send_data_i = 1'b1;
      send_frame("t2c", 3, 3, 1, 0, 32'h0D, -1, w);
      send_data_i = 1'b0;
      step();

      // 3: three back-to-back frames
      baud_rate_i = 32'd2; data_bits_i = 4'd8; parity_en_i = 1'b0;
      push(32'hA5); push(32'h3C); push(32'h81);
      p0 = pop_cnt;
      send_data_i = 1'b1;
      send_frame("t3a", 2, 8, 0, 0, 32'hA5, -1, w);
      check("t3a_clr", send_data_clr_o, 0);
      send_frame("t3b", 2, 8, 0, 0, 32'h3C, -1, w);
      check("t3b_gap", w, 0);
      send_frame("t3c", 2, 8, 0, 0, 32'h81, -1, w);
      check("t3c_gap", w, 0);
      check("t3_pops", pop_cnt - p0, 3);
      check("t3_clr", send_data_clr_o, 1);
      check("t3_nopop", fifo_pop_o, 0);
      send_data_i = 1'b0;
      step();

      // 4: illegal data_bits, then a legal start clears the error
      push(32'h5A);
      p0 = pop_cnt;
      data_bits_i = 4'd0;
      send_data_i = 1'b1;
      #1;
      check("t4_clr0", send_data_clr_o, 1);
      check("t4_pop0", fifo_pop_o, 0);
      step();
      send_data_i = 1'b0;
      check("t4_err0", data_bits_error_o, 1);
      check("t4_tx0", tx_o, 1);
      step();
      check("t4_err_sticky", data_bits_error_o, 1);
      check("t4_pops0", pop_cnt - p0, 0);
      data_bits_i = 4'd8;
      send_data_i = 1'b1;
      send_frame("t4ok", 2, 8, 0, 0, 32'h5A, -1, w);
      check("t4_err_cleared", data_bits_error_o, 0);
      send_data_i = 1'b0;
      step();
      push(32'h11);
      p0 = pop_cnt;
      data_bits_i = 4'd9;
      send_data_i = 1'b1;
      #1;
      check("t4_clr9", send_data_clr_o, 1);
      check("t4_pop9", fifo_pop_o, 0);
      step();
      send_data_i = 1'b0;
      check("t4_err9", data_bits_error_o, 1);
      check("t4_tx9", tx_o, 1);
      step();
      check("t4_pops9", pop_cnt - p0, 0);

      // 5: reset mid-DATA (the pending 0x11 entry is popped by this frame)
      data_bits_i = 4'd8; baud_rate_i = 32'd4;
      p0 = pop_cnt;
      send_data_i = 1'b1;
      #1;
      check("t5_pop", fifo_pop_o, 1);
      step();
      send_data_i = 1'b0;
      repeat (8) step();
      check("t5_busy_before", busy_o, 1);
      #3;
      rst = 1'b1;
      #1;
      check("t5_tx_rst", tx_o, 1);
      check("t5_busy_rst", busy_o, 0);
      step();
      rst = 1'b0;
      repeat (3) step();
      check("t5_pops", pop_cnt - p0, 1);
      check("t5_idle_tx", tx_o, 1);
      check("t5_idle_busy", busy_o, 0);

      // 6: baud 0 -> one cycle per bit; CSR writes mid-frame ignored
      baud_rate_i = 32'd0; data_bits_i = 4'd8; parity_en_i = 1'b1; odd_parity_i = 1'b1;
      push(32'hC3);
      b0 = busy_cnt;
      send_data_i = 1'b1;
      send_frame("t6", 1, 8, 1, 1, 32'hC3, 2, w);
      check("t6_busy_cycles", busy_cnt - b0, 11);
      send_data_i = 1'b0;
      step();

      // 7: maximum baud must not wrap the counter
      baud_rate_i = 32'hFFFF_FFFF;
      push(32'h00);
      send_data_i = 1'b1;
      #1;
      check("t7_pop", fifo_pop_o, 1);
      step();
      send_data_i = 1'b0;
      repeat (20) step();
      check("t7_tx_start", tx_o, 0);
      check("t7_busy", busy_o, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("t7_tx_after", tx_o, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
